// File: rtl/ddr3_rw_sched_pkg.sv
// ddr3_rw_sched_pkg: shared ddr3 scheduler states and AXI burst/response constants
package ddr3_rw_sched_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;
  localparam int DDR3_BL = 8;
endpackage

// File: rtl/cmd_slot.sv
// cmd_slot: one-entry registered valid/ready buffer driving the controller command port
module cmd_slot #(
  parameter int W = 38
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         free,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data
);
  assign free = ~out_valid | out_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (free) begin
      out_valid <= in_valid;
      if (in_valid) out_data <= in_data;
    end
  end
endmodule

// File: rtl/ddr3_rw_sched.sv
// ddr3_rw_sched: burst-aware read/write arbiter feeding BL8 commands to a DDR3 controller
module ddr3_rw_sched
  import ddr3_rw_sched_pkg::*;
#(
  parameter int ADDRS   = 32,
  parameter int REQID   = 4,
  parameter int MAX_RUN = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             wr_store_i,
  output logic             wr_accept_o,
  input  logic             wr_wseq_i,
  input  logic [REQID-1:0] wr_wrid_i,
  input  logic [ADDRS-1:0] wr_addr_i,
  input  logic             wr_dvalid_i,
  input  logic             rd_fetch_i,
  output logic             rd_accept_o,
  input  logic             rd_rseq_i,
  input  logic [REQID-1:0] rd_rdid_i,
  input  logic [ADDRS-1:0] rd_addr_i,
  output logic             ctl_run_o,
  input  logic             ctl_rdy_i,
  output logic             ctl_read_o,
  output logic             ctl_seq_o,
  output logic [REQID-1:0] ctl_id_o,
  output logic [ADDRS-1:0] ctl_addr_o,
  output logic             err_o
);
  localparam int CW = $clog2(MAX_RUN + 1);
  localparam int W  = ADDRS + REQID + 2;
  state_t state, nxt, oth, idle_pick;
  logic [CW-1:0] run_cnt;
  logic last_rd, free, wr_el, rd_el, own_el, oth_el, own_seq, bnd, run_max, first, acc, hd_seq;
  logic [W-1:0] slot_in, slot_out;
  always_comb begin
    wr_el = wr_store_i & wr_dvalid_i;
    rd_el = rd_fetch_i;
    own_el = state == ST_READ ? rd_el : wr_el;
    oth_el = state == ST_READ ? wr_el : rd_el;
    own_seq = state == ST_READ ? rd_rseq_i : wr_wseq_i;
    oth = state == ST_READ ? ST_WRITE : ST_READ;
    run_max = run_cnt >= CW'(MAX_RUN);
    bnd = ~own_el | ~own_seq;
    // run_cnt==0 only before the first command, so writes win the very first tie
    idle_pick = (wr_el & rd_el) ? ((last_rd | run_cnt == '0) ? ST_WRITE : ST_READ) :
                wr_el ? ST_WRITE : rd_el ? ST_READ : ST_IDLE;
    nxt = state == ST_IDLE ? idle_pick :
          ~bnd ? state :
          (oth_el & (run_max | ~own_el)) ? oth :
          own_el ? state : ST_IDLE;
    wr_accept_o = ~reset & free & (nxt == ST_WRITE) & wr_el;
    rd_accept_o = ~reset & free & (nxt == ST_READ) & rd_el;
    acc = wr_accept_o | rd_accept_o;
    first = state != nxt;
    hd_seq = rd_accept_o ? rd_rseq_i : wr_wseq_i;
    slot_in = rd_accept_o ? {1'b1, hd_seq & ~first, rd_rdid_i, rd_addr_i}
                          : {1'b0, hd_seq & ~first, wr_wrid_i, wr_addr_i};
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_IDLE;
      run_cnt <= '0;
      last_rd <= 1'b0;
      err_o   <= 1'b0;
    end else if (free) begin
      state <= nxt;
      if (acc) begin
        run_cnt <= first ? CW'(1) : run_max ? run_cnt : run_cnt + CW'(1);
        last_rd <= rd_accept_o;
        err_o   <= err_o | (first & hd_seq);
      end
    end
  end
  cmd_slot #(.W(W)) u_slot (
    .clock    (clock),
    .reset    (reset),
    .in_valid (acc),
    .in_data  (slot_in),
    .free     (free),
    .out_ready(ctl_rdy_i),
    .out_valid(ctl_run_o),
    .out_data (slot_out)
  );
  assign {ctl_read_o, ctl_seq_o, ctl_id_o, ctl_addr_o} = slot_out;
endmodule

// File: tb/tb_ddr3_rw_sched.sv
// tb_ddr3_rw_sched: directed vector table plus hand-written burst, contention, gating and reset sequences
module tb_ddr3_rw_sched;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic wr_store_i, wr_accept_o, wr_wseq_i, wr_dvalid_i;
  logic rd_fetch_i, rd_accept_o, rd_rseq_i;
  logic [3:0] wr_wrid_i, rd_rdid_i, ctl_id_o;
  logic [31:0] wr_addr_i, rd_addr_i, ctl_addr_o;
  logic ctl_run_o, ctl_rdy_i, ctl_read_o, ctl_seq_o, err_o;
  int checks = 0, failures = 0, wn = 0, rn = 0;
  logic pw, pr;
  typedef struct {
    logic ws, wd, wq, rf, rq, rdy;
    logic e_wa, e_ra, e_run, e_read, e_seq, e_err;
  } vec_t;
  vec_t tbl[15];
  logic rd_order[$];

  always #5 clock = ~clock;

  ddr3_rw_sched dut (
    .clock(clock), .reset(reset),
    .wr_store_i(wr_store_i), .wr_accept_o(wr_accept_o), .wr_wseq_i(wr_wseq_i),
    .wr_wrid_i(wr_wrid_i), .wr_addr_i(wr_addr_i), .wr_dvalid_i(wr_dvalid_i),
    .rd_fetch_i(rd_fetch_i), .rd_accept_o(rd_accept_o), .rd_rseq_i(rd_rseq_i),
    .rd_rdid_i(rd_rdid_i), .rd_addr_i(rd_addr_i),
    .ctl_run_o(ctl_run_o), .ctl_rdy_i(ctl_rdy_i), .ctl_read_o(ctl_read_o),
    .ctl_seq_o(ctl_seq_o), .ctl_id_o(ctl_id_o), .ctl_addr_o(ctl_addr_o), .err_o(err_o)
  );

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h want %0h", nm, a, e);
    end
  endtask

  task automatic set_in(input logic ws, wd, wq, rf, rq, rdy);
    wr_store_i = ws; wr_dvalid_i = wd; wr_wseq_i = wq;
    rd_fetch_i = rf; rd_rseq_i = rq; ctl_rdy_i = rdy;
  endtask

  task automatic drive_heads();
    wr_addr_i = 32'h1000 + wn; wr_wrid_i = 4'(wn);
    rd_addr_i = 32'h2000 + rn; rd_rdid_i = 4'(rn + 8);
  endtask

  task automatic fin_cycle();
    pw = wr_accept_o; pr = rd_accept_o;
    chk("accept_mutex", 32'(pw & pr), 0);
    @(posedge clock); #1;
    if (pw) wn++;
    if (pr) rn++;
    drive_heads();
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_run"}, 32'(ctl_run_o), 0);
    chk({tag, "_read"}, 32'(ctl_read_o), 0);
    chk({tag, "_seq"}, 32'(ctl_seq_o), 0);
    chk({tag, "_id"}, 32'(ctl_id_o), 0);
    chk({tag, "_addr"}, ctl_addr_o, 0);
    chk({tag, "_err"}, 32'(err_o), 0);
    chk({tag, "_wacc"}, 32'(wr_accept_o), 0);
    chk({tag, "_racc"}, 32'(rd_accept_o), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    set_in(0, 0, 0, 0, 0, 1);
    @(posedge clock); #1;
    reset = 1'b0; wn = 0; rn = 0;
    drive_heads();
  endtask

  initial begin
    // ws wd wq rf rq rdy | wa ra run read seq err
    tbl[0]  = '{1,1,0,0,0,1, 1,0,0,0,0,0};
    tbl[1]  = '{1,1,1,0,0,1, 1,0,1,0,0,0};
    tbl[2]  = '{1,1,1,0,0,1, 1,0,1,0,1,0};
    tbl[3]  = '{1,1,1,0,0,1, 1,0,1,0,1,0};
    tbl[4]  = '{0,0,0,0,0,1, 0,0,1,0,1,0};
    tbl[5]  = '{0,0,0,0,0,1, 0,0,0,0,0,0};
    tbl[6]  = '{0,0,0,1,1,1, 0,1,0,0,0,0};
    tbl[7]  = '{0,0,0,0,0,1, 0,0,1,1,0,1};
    tbl[8]  = '{0,0,0,0,0,1, 0,0,0,0,0,1};
    tbl[9]  = '{1,1,0,0,0,0, 1,0,0,0,0,1};
    tbl[10] = '{1,1,0,0,0,0, 0,0,1,0,0,1};
    tbl[11] = '{1,1,0,0,0,0, 0,0,1,0,0,1};
    tbl[12] = '{1,1,0,0,0,1, 1,0,1,0,0,1};
    tbl[13] = '{0,0,0,0,0,1, 0,0,1,0,0,1};
    tbl[14] = '{0,0,0,0,0,1, 0,0,0,0,0,1};

    // reset with both sides requesting: everything must read zero
    set_in(1, 1, 0, 1, 0, 1);
    drive_heads();
    repeat (2) @(posedge clock);
    @(negedge clock);
    chk_rst("rst0");
    @(posedge clock); #1;
    reset = 1'b0; wn = 0; rn = 0;
    drive_heads();

    // table: write burst, read with bad seq, backpressured writes
    for (int i = 0; i < 15; i++) begin
      set_in(tbl[i].ws, tbl[i].wd, tbl[i].wq, tbl[i].rf, tbl[i].rq, tbl[i].rdy);
      @(negedge clock);
      chk($sformatf("v%0d_wacc", i), 32'(wr_accept_o), 32'(tbl[i].e_wa));
      chk($sformatf("v%0d_racc", i), 32'(rd_accept_o), 32'(tbl[i].e_ra));
      chk($sformatf("v%0d_run", i), 32'(ctl_run_o), 32'(tbl[i].e_run));
      chk($sformatf("v%0d_err", i), 32'(err_o), 32'(tbl[i].e_err));
      if (tbl[i].e_run) begin
        chk($sformatf("v%0d_read", i), 32'(ctl_read_o), 32'(tbl[i].e_read));
        chk($sformatf("v%0d_seq", i), 32'(ctl_seq_o), 32'(tbl[i].e_seq));
      end
      fin_cycle();
    end

    // contention: 4 writes, 4 reads, ... back to back
    do_reset();
    begin
      int ew = 0, er = 0;
      for (int c = 0; c < 17; c++) begin
        set_in(1, 1, 0, 1, 0, 1);
        @(negedge clock);
        if (c >= 1) begin
          chk($sformatf("cont%0d_run", c), 32'(ctl_run_o), 1);
          chk($sformatf("cont%0d_read", c), 32'(ctl_read_o), ((c - 1) / 4) % 2);
          if (((c - 1) / 4) % 2 == 1) begin
            chk($sformatf("cont%0d_addr", c), ctl_addr_o, 32'h2000 + er);
            er++;
          end else begin
            chk($sformatf("cont%0d_addr", c), ctl_addr_o, 32'h1000 + ew);
            ew++;
          end
        end
        fin_cycle();
      end
    end

    // burst lock: 8-beat write burst must finish before a read pending since cycle 2
    do_reset();
    rd_order.delete();
    for (int c = 0; c < 13; c++) begin
      set_in(wn < 8, 1, wn != 0, c >= 2, 0, 1);
      @(negedge clock);
      if (ctl_run_o) rd_order.push_back(ctl_read_o);
      fin_cycle();
    end
    chk("lock_count", 32'(rd_order.size() >= 9), 1);
    for (int i = 0; i < 9 && i < rd_order.size(); i++)
      chk($sformatf("lock_cmd%0d_read", i), 32'(rd_order[i]), i == 8);

    // data gating: write head without data never pops, read is served
    do_reset();
    for (int c = 0; c < 11; c++) begin
      set_in(1, c >= 10, 0, rn < 1, 0, 1);
      @(negedge clock);
      chk($sformatf("gate%0d_wacc", c), 32'(wr_accept_o), c == 10);
      if (c < 10) chk($sformatf("gate%0d_racc", c), 32'(rd_accept_o), c == 0);
      if (c == 1) chk("gate_read_cmd", 32'({ctl_run_o, ctl_read_o}), 3);
      fin_cycle();
    end
    set_in(0, 0, 0, 0, 0, 1);
    @(negedge clock);
    chk("gate_wr_cmd", 32'({ctl_run_o, ctl_read_o}), 2);
    chk("gate_wr_addr", ctl_addr_o, 32'h1000);
    fin_cycle();

    // backpressure holds the slot, then a single reset cycle clears it
    do_reset();
    set_in(1, 1, 0, 0, 0, 0);
    @(negedge clock);
    chk("bp_first_wacc", 32'(wr_accept_o), 1);
    fin_cycle();
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      chk($sformatf("bp%0d_run", c), 32'(ctl_run_o), 1);
      chk($sformatf("bp%0d_addr", c), ctl_addr_o, 32'h1000);
      chk($sformatf("bp%0d_id", c), 32'(ctl_id_o), 0);
      chk($sformatf("bp%0d_rdseq", c), 32'({ctl_read_o, ctl_seq_o}), 0);
      chk($sformatf("bp%0d_wacc", c), 32'(wr_accept_o), 0);
      fin_cycle();
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk_rst("bp_rst");
    @(posedge clock); #1;
    reset = 1'b0; wn = 0; rn = 0;
    drive_heads();

    // error: first read after entering READ carries seq=1
    set_in(0, 0, 0, 1, 1, 1);
    @(negedge clock);
    chk("err_racc", 32'(rd_accept_o), 1);
    chk("err_pre", 32'(err_o), 0);
    fin_cycle();
    set_in(0, 0, 0, 0, 0, 1);
    @(negedge clock);
    chk("err_cmd", 32'({ctl_run_o, ctl_read_o, ctl_seq_o}), 3'b110);
    chk("err_id", 32'(ctl_id_o), 8);
    chk("err_set", 32'(err_o), 1);
    fin_cycle();
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      chk($sformatf("err_sticky%0d", c), 32'(err_o), 1);
      fin_cycle();
    end
    reset = 1'b1;
    @(posedge clock);
    @(negedge clock);
    chk("err_cleared", 32'(err_o), 0);
    @(posedge clock); #1;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
